// File: rtl/popcount_acc.sv
// popcount_acc: pipelined population-count accumulator.
// Each accepted beat is reduced to a bit count by a registered adder tree.
// Counts are summed per frame into a saturating accumulator, and one total
// per frame is presented on a valid/ready output.
module popcount_acc #(
  parameter int N_IN  = 15,
  parameter int PIPE  = 2,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  // Width of a full-beat count, tree depth and leaf count of the padded tree.
  localparam int CW   = $clog2(N_IN + 1);
  localparam int LV   = $clog2(N_IN);
  localparam int P    = 1 << LV;
  localparam int NMID = (PIPE > 1) ? PIPE - 1 : 1;

  // One partial count per tree node; after level k only the first P>>k
  // entries are nonzero. No partial count can exceed N_IN, so CW bits suffice.
  typedef logic [P-1:0][CW-1:0] vec_t;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  // Apply tree levels lo+1..hi: each level adds neighbouring node pairs.
  function automatic vec_t reduce_levels(input vec_t v, input int lo, input int hi);
    vec_t cur;
    vec_t nxt;
    cur = v;
    for (int k = lo; k < hi; k++) begin
      nxt = '0;
      for (int j = 0; j < P / 2; j++) begin
        nxt[j] = cur[2*j] + cur[2*j+1];
      end
      cur = nxt;
    end
    return cur;
  endfunction

  // Finish the tree from level lo; the root ends up in entry 0.
  function automatic logic [CW-1:0] tree_total(input vec_t v, input int lo);
    vec_t r;
    r = reduce_levels(v, lo, LV);
    return r[0];
  endfunction

  logic               stall;
  vec_t               in_vec;
  vec_t               mid_reg [0:NMID-1];
  logic [CW-1:0]      cnt_reg;
  logic [PIPE-1:0]    vld_reg;
  logic [PIPE-1:0]    lst_reg;
  logic               cnt_valid;
  logic               cnt_last;

  state_t             state_reg;
  state_t             state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic               sat_reg;
  logic [ACC_W-1:0]   acc_base;
  logic               sat_base;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;
  logic               sat_next;

  logic               out_valid_reg;
  logic [ACC_W-1:0]   out_count_reg;
  logic               out_sat_reg;

  // A held result freezes the whole datapath, so nothing is lost or duplicated.
  assign stall     = out_valid_reg & ~out_ready;
  assign in_ready  = ~stall;
  assign cnt_valid = vld_reg[PIPE-1];
  assign cnt_last  = lst_reg[PIPE-1];

  // Leaves of the tree: one count per input bit, zero for the padding leaves.
  for (genvar gi = 0; gi < P; gi++) begin : g_leaf
    if (gi < N_IN) begin : g_bit
      assign in_vec[gi] = CW'(in_data[gi]);
    end else begin : g_pad
      assign in_vec[gi] = '0;
    end
  end

  // Tree stages: levels are split evenly across PIPE register stages.
  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    localparam int LO = (gi * LV) / PIPE;
    localparam int HI = ((gi + 1) * LV) / PIPE;
    vec_t stage_in;

    if (gi == 0) begin : g_first
      assign stage_in = in_vec;
    end else begin : g_next
      assign stage_in = mid_reg[gi-1];
    end

    if (gi < PIPE - 1) begin : g_mid
      // Intermediate stage register: partial sums after level HI.
      always_ff @(posedge clk) begin
        if (reset) begin
          mid_reg[gi] <= '0;
        end else if (!stall) begin
          mid_reg[gi] <= reduce_levels(stage_in, LO, HI);
        end
      end
    end else begin : g_last
      // Final stage register: the complete beat count.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (!stall) begin
          cnt_reg <= tree_total(stage_in, LO);
        end
      end
    end
  end

  // Valid and last flags travel alongside the counts through every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg <= '0;
      lst_reg <= '0;
    end else if (!stall) begin
      vld_reg[0] <= in_valid & in_ready;
      lst_reg[0] <= in_last;
      for (int s = 1; s < PIPE; s++) begin
        vld_reg[s] <= vld_reg[s-1];
        lst_reg[s] <= lst_reg[s-1];
      end
    end
  end

  // Next frame state and saturating sum for the arriving count.
  always_comb begin
    state_next = state_reg;
    acc_base   = (state_reg == S_IDLE) ? '0 : acc_reg;
    sat_base   = (state_reg == S_IDLE) ? 1'b0 : sat_reg;
    sum        = {1'b0, acc_base} + (ACC_W + 1)'(cnt_reg);
    acc_next   = sum[ACC_W-1:0];
    sat_next   = sat_base;
    if (sum[ACC_W]) begin
      acc_next = '1;
      sat_next = 1'b1;
    end
    if (cnt_valid) begin
      state_next = cnt_last ? S_IDLE : S_ACCUM;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else if (!stall) begin
      state_reg <= state_next;
    end
  end

  // Accumulator and output register; a last beat publishes and clears the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg       <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_count_reg <= '0;
      out_sat_reg   <= 1'b0;
    end else if (!stall) begin
      // Not stalled means any pending result is being taken this cycle.
      out_valid_reg <= 1'b0;
      if (cnt_valid) begin
        if (cnt_last) begin
          out_count_reg <= acc_next;
          out_sat_reg   <= sat_next;
          out_valid_reg <= 1'b1;
          acc_reg       <= '0;
          sat_reg       <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          sat_reg <= sat_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_count = out_count_reg;
  assign out_sat   = out_sat_reg;

endmodule
